cp0_regfile: RTL



---
 rtl/cp0_regfile_pkg.sv | 58 +++++
 rtl/cp0_regfile_if.sv | 41 ++++
 rtl/cp0_regfile_timer.sv | 66 ++++++
 rtl/cp0_regfile.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// ============================================================================
// cp0defines : CP0 register numbers, exception type codes and field positions
// Rev 1.0
// ============================================================================
`default_nettype none

package cp0defines;

    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_COUNT    = 5'd9,
        CP0_COMPARE  = 5'd11,
        CP0_STATUS   = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14
    } cp0_reg_e;

    localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0;
    localparam logic [31:0] EXC_TYPE_INT   = 32'h1;
    localparam logic [31:0] EXC_TYPE_ADEL  = 32'h4;
    localparam logic [31:0] EXC_TYPE_ADES  = 32'h5;
    localparam logic [31:0] EXC_TYPE_SYS   = 32'h8;
    localparam logic [31:0] EXC_TYPE_BP    = 32'h9;
    localparam logic [31:0] EXC_TYPE_RI    = 32'ha;
    localparam logic [31:0] EXC_TYPE_OV    = 32'hc;
    localparam logic [31:0] EXC_TYPE_ERET  = 32'he;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
        case (exc_type)
            EXC_TYPE_INT:  return EXCCODE_INT;
            EXC_TYPE_ADEL: return EXCCODE_ADEL;
            EXC_TYPE_ADES: return EXCCODE_ADES;
            EXC_TYPE_SYS:  return EXCCODE_SYS;
            EXC_TYPE_BP:   return EXCCODE_BP;
            EXC_TYPE_RI:   return EXCCODE_RI;
            EXC_TYPE_OV:   return EXCCODE_OV;
            default:       return EXCCODE_INT;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_regfile_if.sv
// ============================================================================
// cp0_regfile_if : MEM-stage access and state-export bundle for the CP0 block
// Rev 1.0
// ============================================================================
`default_nettype none

interface cp0_regfile_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] badvaddr_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, raddr_i, data_i, int_i, except_type_i,
               current_inst_addr_i, is_in_delayslot_i, badvaddr_i,
        input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, int_i, except_type_i,
               current_inst_addr_i, is_in_delayslot_i, badvaddr_i,
        output data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o
    );
endinterface

`default_nettype wire

// File: rtl/cp0_regfile_timer.sv
// ============================================================================
// cp0_timer : Count/Compare timer with clock divider and sticky match interrupt
// Rev 1.0
// ============================================================================
`default_nettype none

module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        count_we,
    input  wire logic        compare_we,
    input  wire logic [31:0] wdata,
    output logic [31:0]      count,
    output logic [31:0]      compare,
    output logic             timer_int
);

    localparam logic c_PHASE_LAST = 1'(COUNT_DIV - 1);

    logic        r_phase;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;
    logic        w_tick;
    logic        w_match;

    assign w_tick  = (r_phase == c_PHASE_LAST);
    assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_phase     <= 1'b0;
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_timer_int <= 1'b0;
        end else begin
            // A software Count write restarts the divider so the next
            // increment lands a full COUNT_DIV period later.
            if (count_we) begin
                r_count <= wdata;
                r_phase <= 1'b0;
            end else if (w_tick) begin
                r_count <= r_count + 32'd1;
                r_phase <= 1'b0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end

            if (compare_we) begin
                r_compare   <= wdata;
                r_timer_int <= 1'b0;
            end else if (w_match) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign count     = r_count;
    assign compare   = r_compare;
    assign timer_int = r_timer_int;

endmodule

`default_nettype wire

// File: rtl/cp0_regfile.sv
// ============================================================================
// cp0_regfile : CP0 register file, MTC0/MFC0 port and exception-commit logic
// Rev 1.0
// ============================================================================
`default_nettype none

module cp0_regfile
    import cp0defines::*;
#(
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    cp0_regfile_if.slave cp0
);

    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;

    logic        w_no_exc;
    logic        w_eret;
    logic        w_commit;
    logic        w_we;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_int;
    logic [31:0] w_cause;

    // Any pending exception flushes the MEM-stage instruction, so its MTC0 dies.
    assign w_no_exc = (cp0.except_type_i == EXC_TYPE_NOEXC);
    assign w_eret   = (cp0.except_type_i == EXC_TYPE_ERET);
    assign w_commit = !w_no_exc && !w_eret;
    assign w_we     = cp0.we_i && w_no_exc;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (w_we && (cp0.waddr_i == CP0_COUNT)),
        .compare_we (w_we && (cp0.waddr_i == CP0_COMPARE)),
        .wdata      (cp0.data_i),
        .count      (w_count),
        .compare    (w_compare),
        .timer_int  (w_timer_int)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_status   <= RESET_STATUS;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_bd       <= 1'b0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_exccode  <= 5'd0;
        end else begin
            r_ip_hw <= cp0.int_i;

            if (w_we) begin
                case (cp0.waddr_i)
                    CP0_STATUS: r_status <= (r_status & ~STATUS_WMASK) |
                                            (cp0.data_i & STATUS_WMASK);
                    CP0_CAUSE:  r_ip_sw  <= cp0.data_i[9:8];
                    CP0_EPC:    r_epc    <= cp0.data_i;
                    default: ;
                endcase
            end

            if (w_commit) begin
                // A nested exception keeps the original return point.
                if (!r_status[STATUS_EXL]) begin
                    r_epc <= cp0.is_in_delayslot_i ? (cp0.current_inst_addr_i - 32'd4)
                                                   : cp0.current_inst_addr_i;
                    r_bd  <= cp0.is_in_delayslot_i;
                end
                r_status[STATUS_EXL] <= 1'b1;
                r_exccode            <= exc_code(cp0.except_type_i);
                if ((cp0.except_type_i == EXC_TYPE_ADEL) ||
                    (cp0.except_type_i == EXC_TYPE_ADES)) begin
                    r_badvaddr <= cp0.badvaddr_i;
                end
            end else if (w_eret) begin
                r_status[STATUS_EXL] <= 1'b0;
            end
        end
    end

    // TI and the timer share IP[7] with int_i[5]; both track the sticky flag directly.
    assign w_cause = {r_bd, w_timer_int, 14'd0,
                      r_ip_hw[5] | w_timer_int, r_ip_hw[4:0], r_ip_sw,
                      1'b0, r_exccode, 2'b00};

    always_comb begin
        cp0.data_o = 32'd0;
        case (cp0.raddr_i)
            CP0_BADVADDR: cp0.data_o = r_badvaddr;
            CP0_COUNT:    cp0.data_o = w_count;
            CP0_COMPARE:  cp0.data_o = w_compare;
            CP0_STATUS:   cp0.data_o = r_status;
            CP0_CAUSE:    cp0.data_o = w_cause;
            CP0_EPC:      cp0.data_o = r_epc;
            default:      cp0.data_o = 32'd0;
        endcase
    end

    assign cp0.count_o     = w_count;
    assign cp0.compare_o   = w_compare;
    assign cp0.status_o    = r_status;
    assign cp0.cause_o     = w_cause;
    assign cp0.epc_o       = r_epc;
    assign cp0.badvaddr_o  = r_badvaddr;
    assign cp0.timer_int_o = w_timer_int;

endmodule

`default_nettype wire
